// File: rtl/shift_result_stage_pkg.sv
// Shared definitions for the shifter result stage: default widths, shift
// opcode encodings and the skid-buffer occupancy states.
package shift_result_stage_pkg;

    localparam int SHIFT_DATA_W = 32;
    localparam int SHIFT_TAG_W  = 5;

    localparam logic SHIFT_OP_SLL = 1'b0;
    localparam logic SHIFT_OP_SRA = 1'b1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skidState_e;

endpackage

// File: rtl/shift_result_stage_skid_buffer.sv
// Generic two-entry skid buffer. The main register is always the head of
// the queue; the skid register only holds a second entry when the head is
// stalled. in_ready depends only on registered occupancy, so back-pressure
// from out_ready never reaches in_ready combinationally.
module shift_skid_buffer
    import shift_result_stage_pkg::*;
#(
    parameter int PAYLOAD_W = 40
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data
);

    skidState_e           state_q, state_d;
    logic [PAYLOAD_W-1:0] mainData_q, mainData_d;
    logic [PAYLOAD_W-1:0] skidData_q, skidData_d;
    logic                 accept;
    logic                 deliver;
    logic                 loadIn;

    assign in_ready  = reset_n && (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = mainData_q;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign loadIn    = accept && !flush;

    // Next occupancy and register loads; a flush empties the buffer and
    // drops any entry offered on the same cycle.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        skidData_d = skidData_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (loadIn) begin
                    mainData_d = in_data;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (loadIn && deliver) begin
                    mainData_d = in_data;
                end else if (loadIn) begin
                    skidData_d = in_data;
                    state_d    = ST_FULL;
                end else if (deliver) begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    mainData_d = skidData_q;
                    state_d    = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // Occupancy and payload registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            mainData_q <= '0;
            skidData_q <= '0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            skidData_q <= skidData_d;
        end
    end

endmodule

// File: rtl/shift_result_stage.sv
// Registered output stage behind the shifter. Captures result, destination
// tag, opcode and zero/sign flags into a skid buffer, decodes the writeback
// enable ($r0 is never written) and counts back-pressure cycles.
module shift_result_stage
    import shift_result_stage_pkg::*;
#(
    parameter int DATA_W = SHIFT_DATA_W,
    parameter int TAG_W  = SHIFT_TAG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [TAG_W-1:0]  in_rd,
    input  logic              in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_rd,
    output logic              out_op,
    output logic              out_we,
    output logic              out_is_zero,
    output logic              out_is_neg,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int PAYLOAD_W = DATA_W + TAG_W + 3;

    logic [PAYLOAD_W-1:0] inPayload;
    logic [PAYLOAD_W-1:0] outPayload;
    logic                 inIsZero;
    logic                 inIsNeg;
    logic [CNT_W-1:0]     stallCount_q, stallCount_d;

    // Flags are derived once at capture and travel with the entry.
    assign inIsZero  = (in_result == '0);
    assign inIsNeg   = in_result[DATA_W-1];
    assign inPayload = {in_op, in_rd, inIsNeg, inIsZero, in_result};

    shift_skid_buffer #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (inPayload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (outPayload)
    );

    assign out_result  = outPayload[DATA_W-1:0];
    assign out_is_zero = outPayload[DATA_W];
    assign out_is_neg  = outPayload[DATA_W+1];
    assign out_rd      = outPayload[DATA_W+2 +: TAG_W];
    assign out_op      = outPayload[PAYLOAD_W-1];
    assign out_we      = out_valid && (out_rd != '0);
    assign stall_count = stallCount_q;

    // Saturating increment whenever the head is held by writeback.
    always_comb begin
        stallCount_d = stallCount_q;
        if (out_valid && !out_ready && (stallCount_q != {CNT_W{1'b1}})) begin
            stallCount_d = stallCount_q + 1'b1;
        end
    end

    // Stall counter is cleared by reset only; flush leaves it alone.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stallCount_q <= '0;
        end else begin
            stallCount_q <= stallCount_d;
        end
    end

endmodule
